// File: rtl/accum_ctrl_pkg.sv
// Typed views of the shared opcode and state encodings.
package accum_ctrl_pkg;

`include "alu_defs.v"

    typedef enum logic [1:0] {
        OP_LOAD = `OP_LOAD,
        OP_ADD  = `OP_ADD,
        OP_SUB  = `OP_SUB,
        OP_CLR  = `OP_CLR
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = `ST_IDLE,
        S_EXEC = `ST_EXEC,
        S_RESP = `ST_RESP
    } state_t;

endpackage

// File: rtl/accum_ctrl_add_sub.sv
// Add/subtract stage: subtraction adds the W-bit two's complement of y, so y=0 gives no carry.
module add_sub #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         add_sub,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] y_eff;

    assign y_eff      = add_sub ? (~y + W'(1)) : y;
    assign {cout, s}  = {1'b0, x} + {1'b0, y_eff};

endmodule

// File: rtl/alu_defs.v
// Shared encodings for the accumulator controller: command opcodes and FSM states.
`ifndef ALU_DEFS_V
`define ALU_DEFS_V

`define OP_LOAD 2'b00
`define OP_ADD  2'b01
`define OP_SUB  2'b10
`define OP_CLR  2'b11

`define ST_IDLE 2'd0
`define ST_EXEC 2'd1
`define ST_RESP 2'd2

`endif

// File: rtl/accum_ctrl.sv
// Accumulator controller: one command per IDLE/EXEC/RESP pass with valid/ready on both sides.
module accum_ctrl
    import accum_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] acc,
    output logic         flag_c,
    output logic         flag_z,
    output logic         flag_v
);

    state_t       state_reg, state_next;
    op_t          op_reg;
    logic [W-1:0] data_reg;
    logic [W-1:0] acc_reg, acc_next;
    logic         c_reg, c_next;
    logic         z_reg, z_next;
    logic         v_reg, v_next;
    logic [W-1:0] sum;
    logic         cout;
    logic         sub_sel;

    assign sub_sel = (op_reg == OP_SUB);

    add_sub #(.W(W)) u_add_sub (
        .x       (acc_reg),
        .y       (data_reg),
        .add_sub (sub_sel),
        .s       (sum),
        .cout    (cout)
    );

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        c_next     = c_reg;
        z_next     = z_reg;
        v_next     = v_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_RESP;
                case (op_reg)
                    OP_LOAD: begin
                        acc_next = data_reg;
                        c_next   = 1'b0;
                        v_next   = 1'b0;
                        z_next   = (data_reg == '0);
                    end
                    OP_ADD: begin
                        acc_next = sum;
                        c_next   = cout;
                        z_next   = (sum == '0);
                        v_next   = (acc_reg[W-1] == data_reg[W-1]) && (sum[W-1] != acc_reg[W-1]);
                    end
                    OP_SUB: begin
                        acc_next = sum;
                        c_next   = cout;
                        z_next   = (sum == '0);
                        v_next   = (acc_reg[W-1] != data_reg[W-1]) && (sum[W-1] != acc_reg[W-1]);
                    end
                    default: begin
                        acc_next = '0;
                        c_next   = 1'b0;
                        v_next   = 1'b0;
                        z_next   = 1'b1;
                    end
                endcase
            end
            S_RESP: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_LOAD;
            data_reg  <= '0;
            acc_reg   <= '0;
            c_reg     <= 1'b0;
            z_reg     <= 1'b0;
            v_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            c_reg     <= c_next;
            z_reg     <= z_next;
            v_reg     <= v_next;
            if (state_reg == S_IDLE && in_valid) begin
                op_reg   <= op_t'(in_op);
                data_reg <= in_data;
            end
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_RESP);
    assign acc       = acc_reg;
    assign flag_c    = c_reg;
    assign flag_z    = z_reg;
    assign flag_v    = v_reg;

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl with a result scoreboard filled at command issue.
module tb_accum_ctrl;

    typedef struct packed {
        logic [3:0] acc;
        logic       c;
        logic       z;
        logic       v;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       flag_v;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t sb[$];
    logic [3:0] m_acc;

    accum_ctrl #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour taken straight from the command definitions.
    task automatic model(input logic [1:0] op, input logic [3:0] d, output res_t r);
        logic [4:0] s5;
        logic [3:0] neg;
        logic [3:0] a;
        a = m_acc;
        r = '0;
        case (op)
            2'b00: begin r.acc = d; r.c = 1'b0; r.v = 1'b0; r.z = (d == 4'h0); end
            2'b01: begin
                s5 = {1'b0, a} + {1'b0, d};
                r.acc = s5[3:0]; r.c = s5[4]; r.z = (s5[3:0] == 4'h0);
                r.v = (a[3] == d[3]) && (s5[3] != a[3]);
            end
            2'b10: begin
                neg = 4'h0 - d;
                s5 = {1'b0, a} + {1'b0, neg};
                r.acc = s5[3:0]; r.c = s5[4]; r.z = (s5[3:0] == 4'h0);
                r.v = (a[3] != d[3]) && (s5[3] != a[3]);
            end
            default: begin r.acc = 4'h0; r.c = 1'b0; r.v = 1'b0; r.z = 1'b1; end
        endcase
        m_acc = r.acc;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_idle", 8'(in_ready), 8'd1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input int hold);
        res_t e;
        wait_ready();
        model(op, d, e);
        sb.push_back(e);
        in_valid = 1'b1; in_op = op; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("out_valid_exec", 8'(out_valid), 8'd0);
        chk("in_ready_exec", 8'(in_ready), 8'd0);
        @(posedge clk); #1;
        chk("out_valid_lat2", 8'(out_valid), 8'd1);
        e = sb.pop_front();
        chk("acc", 8'(acc), 8'(e.acc));
        chk("flag_c", 8'(flag_c), 8'(e.c));
        chk("flag_z", 8'(flag_z), 8'(e.z));
        chk("flag_v", 8'(flag_v), 8'(e.v));
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0); in_op = 2'b11; in_data = 4'hA;
            @(posedge clk); #1;
            chk("bp_out_valid", 8'(out_valid), 8'd1);
            chk("bp_acc", 8'(acc), 8'(e.acc));
            chk("bp_in_ready", 8'(in_ready), 8'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_done", 8'(out_valid), 8'd0);
        chk("in_ready_done", 8'(in_ready), 8'd1);
        chk("acc_hold", 8'(acc), 8'(e.acc));
        $display("txn op=%0d data=%h hold=%0d -> acc=%h c=%b z=%b v=%b (exp acc=%h c=%b z=%b v=%b)",
                 op, d, hold, acc, flag_c, flag_z, flag_v, e.acc, e.c, e.z, e.v);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_data = 4'h0; out_ready = 1'b0;
        m_acc = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 8'(in_ready), 8'd1);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_acc", 8'(acc), 8'd0);
        chk("rst_flags", 8'({flag_c, flag_z, flag_v}), 8'd0);
        $display("txn reset release: in_ready=%b out_valid=%b acc=%h", in_ready, out_valid, acc);

        do_cmd(2'b00, 4'h5, 0);
        do_cmd(2'b01, 4'h3, 0);
        chk("add_5_3", 8'({acc, flag_c, flag_z, flag_v}), 8'({4'h8, 1'b0, 1'b0, 1'b1}));
        do_cmd(2'b00, 4'h3, 0);
        do_cmd(2'b10, 4'h5, 0);
        chk("sub_3_5", 8'({acc, flag_c, flag_v}), 8'({4'hE, 1'b0, 1'b0}));
        do_cmd(2'b00, 4'h9, 0);
        do_cmd(2'b10, 4'h4, 0);
        chk("sub_9_4", 8'({acc, flag_c, flag_v}), 8'({4'h5, 1'b1, 1'b1}));
        do_cmd(2'b00, 4'h1, 0);
        do_cmd(2'b01, 4'hF, 0);
        chk("add_1_f", 8'({acc, flag_c, flag_z, flag_v}), 8'({4'h0, 1'b1, 1'b1, 1'b0}));
        do_cmd(2'b10, 4'h0, 0);
        chk("sub_0_0", 8'({acc, flag_c, flag_z}), 8'({4'h0, 1'b0, 1'b1}));
        do_cmd(2'b11, 4'h7, 0);

        do_cmd(2'b00, 4'h6, 4);

        for (int k = 0; k < 8; k++) begin
            do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        do_cmd(2'b00, 4'h6, 0);
        wait_ready();
        in_valid = 1'b1; in_op = 2'b01; in_data = 4'h3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_acc", 8'(acc), 8'd0);
        chk("midrst_flags", 8'({flag_c, flag_z, flag_v}), 8'd0);
        chk("midrst_out_valid", 8'(out_valid), 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_acc = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_out_valid", 8'(out_valid), 8'd0);
            chk("post_rst_in_ready", 8'(in_ready), 8'd1);
        end
        $display("txn reset during EXEC: acc=%h out_valid=%b", acc, out_valid);
        do_cmd(2'b00, 4'h7, 0);
        chk("load7_after_rst", 8'(acc), 8'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, meaning the data path width; only W=4 is supported, matching the 4-bit add/sub stage.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, command request.
REQ-005 SHALL have port in_ready, output, 1 bit, block can accept a command.
REQ-006 SHALL have port in_op, input, 2 bits, command: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-007 SHALL have port in_data, input, 4 bits, operand for the command.
REQ-008 SHALL have port out_valid, output, 1 bit, result available.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-010 SHALL have port acc, output, 4 bits, accumulator value.
REQ-011 SHALL have port flag_c, output, 1 bit, carry flag.
REQ-012 SHALL have port flag_z, output, 1 bit, zero flag.
REQ-013 SHALL have port flag_v, output, 1 bit, signed overflow flag.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, EXEC, RESP.
REQ-015 SHALL drive in_ready=1 only in IDLE (combinational from state); in EXEC and RESP, in_valid SHALL be ignored.
REQ-016 SHALL, in IDLE with in_valid=1, register in_op and in_data and go to EXEC; otherwise stay in IDLE.
REQ-017 SHALL, in EXEC, drive the add/sub stage with x=acc, y=registered data, and add_sub=1 for SUB, else 0; capture results at the end of the cycle and go to RESP.
REQ-018 SHALL update on LOAD: acc=data, C=0, V=0, Z=(data==0).
REQ-019 SHALL update on ADD and SUB: acc=s, C=cout as produced by the add/sub stage, Z=(s==0).
REQ-020 SHALL pass cout unmodified; SUB with data=0 therefore yields C=0.
REQ-021 SHALL compute V for ADD as (x[3]==y[3]) && (s[3]!=x[3]).
REQ-022 SHALL compute V for SUB as (x[3]!=y[3]) && (s[3]!=x[3]).
REQ-023 SHALL update on CLR: acc=0, C=0, V=0, Z=1.
REQ-024 SHALL assert out_valid only in RESP; latency is accept edge to out_valid high = 2 cycles.
REQ-025 SHALL hold out_valid, acc and the flags stable in RESP until out_ready=1, then return to IDLE on that edge.
REQ-026 SHALL take out_ready=1 on the same edge RESP is entered as acceptance on the first RESP cycle; peak throughput is one command per 3 cycles.
REQ-027 SHALL leave acc and the flags unchanged outside EXEC.
REQ-028 SHALL take 4-bit wrap-around from the add/sub stage with no saturation.

Reset
REQ-029 SHALL, when rst_n=0, asynchronously force state=IDLE, acc=0, flag_c=0, flag_z=0, flag_v=0, out_valid=0 and the command registers to 0.
REQ-030 SHALL drop any command in EXEC or RESP when reset occurs mid-operation, with no response emitted.
REQ-031 SHALL present in_ready=1 on the first clock edge after rst_n deasserts.

Structure
REQ-032 SHALL place the op encodings (LOAD/ADD/SUB/CLR) and the FSM state encodings in a shared include-guarded defines file, alu_defs.v.
REQ-033 SHALL instantiate exactly one sub-module, add_sub; the block SHALL NOT contain an adder of its own.

Verification
REQ-034 SHALL cover reset release: in_ready=1, out_valid=0, acc=0, all flags 0.
REQ-035 SHALL cover LOAD 5 then ADD 3: acc=8, C=0, Z=0, V=1, with out_valid exactly 2 cycles after each accept.
REQ-036 SHALL cover LOAD 3, SUB 5: acc=0xE, C=0, V=0; then LOAD 9, SUB 4: acc=5, C=1, V=1.
REQ-037 SHALL cover LOAD 1, ADD 0xF: acc=0, Z=1, C=1, V=0; then SUB 0 with acc=0: acc=0, C=0, Z=1.
REQ-038 SHALL cover backpressure: out_ready held low 4 cycles in RESP, with in_valid pulsed throughout -> out_valid held, acc unchanged, in_ready=0, no command accepted.
REQ-039 SHALL cover rst_n pulsed low during EXEC of ADD: outputs clear immediately, no out_valid pulse, and the next LOAD 7 yields acc=7.
